// File: rtl/register_file_pkg.sv
// regfile_pkg: widths, zero-register constant and address/data types shared by the register file.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG = 2**ADDR_W;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/register_file_if.sv
// register_file_if: decode read/issue and writeback signals of the register file.
interface register_file_if;
    import regfile_pkg::*;
    reg_addr_t rs_addr, rt_addr, wr_addr, issue_dst;
    logic rs_used, rt_used, wr_en, issue_en, stall;
    reg_data_t rs_data, rt_data, wr_data;
    logic [ADDR_W:0] pending_cnt;
    modport master (
        output rs_addr, rt_addr, rs_used, rt_used, wr_en, wr_addr, wr_data, issue_en, issue_dst,
        input  rs_data, rt_data, stall, pending_cnt
    );
    modport slave (
        input  rs_addr, rt_addr, rs_used, rt_used, wr_en, wr_addr, wr_data, issue_en, issue_dst,
        output rs_data, rt_data, stall, pending_cnt
    );
endinterface

// File: rtl/register_file_scoreboard.sv
// scoreboard: pending-write bits, RAW/WAW stall and in-flight count.
// REGFILE_BYPASS_EN lets a same-cycle writeback release the hazard immediately.
module scoreboard
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    input  logic rs_used,
    input  logic rt_used,
    input  logic wr_en,
    input  reg_addr_t wr_addr,
    input  logic issue_en,
    input  reg_addr_t issue_dst,
    output logic stall,
    output logic [ADDR_W:0] pending_cnt
);
    logic [NREG-1:0] pending, pend_eff, wr_mask, set_mask, nxt;
    assign wr_mask = wr_en ? NREG'(1) << wr_addr : '0;
`ifdef REGFILE_BYPASS_EN
    assign pend_eff = pending & ~wr_mask;
`else
    assign pend_eff = pending;
`endif
    assign stall = ~reset & ((rs_used & pend_eff[rs_addr]) | (rt_used & pend_eff[rt_addr]) |
                             (issue_en & pend_eff[issue_dst]));
    assign set_mask = (issue_en && !stall && issue_dst != ZERO_REG) ? NREG'(1) << issue_dst : '0;
    // Set is applied after clear so a same-register issue keeps the bit
    assign nxt = (pending & ~wr_mask) | set_mask;
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            pending_cnt <= '0;
        end else begin
            pending <= nxt;
            pending_cnt <= (ADDR_W+1)'($countones(nxt));
        end
    end
endmodule

// File: rtl/register_file.sv
// register_file: 32-entry MIPS register file with r0 hardwired to zero and a pending-write scoreboard.
// REGFILE_BYPASS_EN adds same-cycle writeback-to-read forwarding.
module register_file
    import regfile_pkg::*;
(
    input logic clk,
    input logic reset,
    register_file_if.slave rf
);
    logic [NREG-1:0][DATA_W-1:0] mem;
    scoreboard u_sb (
        .clk(clk), .reset(reset),
        .rs_addr(rf.rs_addr), .rt_addr(rf.rt_addr), .rs_used(rf.rs_used), .rt_used(rf.rt_used),
        .wr_en(rf.wr_en), .wr_addr(rf.wr_addr), .issue_en(rf.issue_en), .issue_dst(rf.issue_dst),
        .stall(rf.stall), .pending_cnt(rf.pending_cnt)
    );
    always_ff @(posedge clk) begin
        if (reset) mem <= '0;
        else if (rf.wr_en && rf.wr_addr != ZERO_REG) mem[rf.wr_addr] <= rf.wr_data;
    end
`ifdef REGFILE_BYPASS_EN
    assign rf.rs_data = rf.rs_addr == ZERO_REG ? '0 :
                        (rf.wr_en && rf.wr_addr == rf.rs_addr) ? rf.wr_data : mem[rf.rs_addr];
    assign rf.rt_data = rf.rt_addr == ZERO_REG ? '0 :
                        (rf.wr_en && rf.wr_addr == rf.rt_addr) ? rf.wr_data : mem[rf.rt_addr];
`else
    assign rf.rs_data = rf.rs_addr == ZERO_REG ? '0 : mem[rf.rs_addr];
    assign rf.rt_data = rf.rt_addr == ZERO_REG ? '0 : mem[rf.rt_addr];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table vectors, directed hazard sequences and random traffic against a reference model.
module tb_register_file;
    import regfile_pkg::*;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    register_file_if rf();
    register_file dut (.clk(clk), .reset(reset), .rf(rf));

    typedef struct {
        bit rs_used, rt_used, wr_en, issue_en;
        reg_addr_t rs, rt, wa, dst;
        reg_data_t wd, e_rs, e_rt;
        bit e_stall;
        int e_cnt;
    } vec_t;

    reg_data_t m_mem [NREG];
    bit m_pend [NREG];
    int compared = 0, mismatched = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_busy(reg_addr_t r);
        return m_pend[r] && !(BYP && rf.wr_en && rf.wr_addr == r);
    endfunction

    function automatic reg_data_t m_read(reg_addr_t r);
        if (r == 0) return '0;
        if (BYP && rf.wr_en && rf.wr_addr == r) return rf.wr_data;
        return m_mem[r];
    endfunction

    function automatic int m_count();
        int n = 0;
        foreach (m_pend[i]) n += int'(m_pend[i]);
        return n;
    endfunction

    task automatic idle();
        rf.rs_addr = '0; rf.rt_addr = '0; rf.rs_used = 0; rf.rt_used = 0;
        rf.wr_en = 0; rf.wr_addr = '0; rf.wr_data = '0; rf.issue_en = 0; rf.issue_dst = '0;
    endtask

    // Compares current outputs with the model, then clocks both forward one cycle
    task automatic cycle(string tag);
        bit st;
        reg_data_t nmem [NREG];
        bit npend [NREG];
        st = !reset && ((rf.rs_used && m_busy(rf.rs_addr)) || (rf.rt_used && m_busy(rf.rt_addr)) ||
                        (rf.issue_en && m_busy(rf.issue_dst)));
        chk({tag, ".rs_data"}, 64'(rf.rs_data), 64'(m_read(rf.rs_addr)));
        chk({tag, ".rt_data"}, 64'(rf.rt_data), 64'(m_read(rf.rt_addr)));
        chk({tag, ".stall"}, 64'(rf.stall), 64'(st));
        chk({tag, ".pending_cnt"}, 64'(rf.pending_cnt), 64'(m_count()));
        nmem = m_mem;
        npend = m_pend;
        if (reset) begin
            foreach (nmem[i]) begin nmem[i] = '0; npend[i] = 0; end
        end else begin
            if (rf.wr_en && rf.wr_addr != 0) begin nmem[rf.wr_addr] = rf.wr_data; npend[rf.wr_addr] = 0; end
            if (rf.issue_en && !st && rf.issue_dst != 0) npend[rf.issue_dst] = 1;
        end
        @(posedge clk);
        m_mem = nmem;
        m_pend = npend;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; idle(); #1;
        cycle("reset");
        reset = 0;
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1; idle();
        @(posedge clk); @(negedge clk);
        foreach (m_mem[i]) begin m_mem[i] = '0; m_pend[i] = 0; end
        reset = 0;

        for (int a = 0; a < NREG; a++) begin
            rf.rs_addr = reg_addr_t'(a); rf.rt_addr = reg_addr_t'(NREG-1-a); #1;
            chk("sweep.zero", 64'(rf.rs_data | rf.rt_data), 64'(0));
            cycle("sweep");
        end

        tbl.push_back('{0,0,0,0, 0,31, 0,0, 0, 0,0, 0,0});
        tbl.push_back('{0,0,1,0, 6,0, 5,0, 32'hDEADBEEF, 0,0, 0,0});
        tbl.push_back('{0,0,0,0, 5,0, 0,0, 0, 32'hDEADBEEF,0, 0,0});
        tbl.push_back('{0,0,1,0, 6,7, 0,0, 32'h1234, 0,0, 0,0});
        tbl.push_back('{0,0,0,0, 0,5, 0,0, 0, 0,32'hDEADBEEF, 0,0});
        tbl.push_back('{0,0,0,1, 0,0, 0,3, 0, 0,0, 0,0});
        tbl.push_back('{0,0,0,1, 0,0, 0,3, 0, 0,0, 1,1});
        tbl.push_back('{0,0,0,1, 0,0, 0,4, 0, 0,0, 0,1});
        tbl.push_back('{1,0,0,0, 3,0, 0,0, 0, 0,0, 1,2});
        tbl.push_back('{0,0,0,0, 3,4, 0,0, 0, 0,0, 0,2});
        tbl.push_back('{0,0,0,1, 0,0, 0,0, 0, 0,0, 0,2});
        tbl.push_back('{0,1,0,0, 0,4, 0,0, 0, 0,0, 1,2});
        tbl.push_back('{0,0,1,0, 5,5, 3,0, 32'h11, 32'hDEADBEEF,32'hDEADBEEF, 0,2});
        tbl.push_back('{1,0,0,0, 3,0, 0,0, 0, 32'h11,0, 0,1});
        foreach (tbl[k]) begin
            rf.rs_used = tbl[k].rs_used; rf.rt_used = tbl[k].rt_used;
            rf.wr_en = tbl[k].wr_en; rf.issue_en = tbl[k].issue_en;
            rf.rs_addr = tbl[k].rs; rf.rt_addr = tbl[k].rt;
            rf.wr_addr = tbl[k].wa; rf.issue_dst = tbl[k].dst; rf.wr_data = tbl[k].wd;
            #1;
            chk($sformatf("vec%0d.rs_data", k), 64'(rf.rs_data), 64'(tbl[k].e_rs));
            chk($sformatf("vec%0d.rt_data", k), 64'(rf.rt_data), 64'(tbl[k].e_rt));
            chk($sformatf("vec%0d.stall", k), 64'(rf.stall), 64'(tbl[k].e_stall));
            chk($sformatf("vec%0d.cnt", k), 64'(rf.pending_cnt), 64'(tbl[k].e_cnt));
            cycle("vec");
        end

        do_reset();
        idle(); rf.issue_en = 1; rf.issue_dst = 8; #1; cycle("lu.issue");
        idle(); rf.rs_addr = 8; rf.rs_used = 1; #1;
        chk("loaduse.stall", 64'(rf.stall), 64'(1));
        cycle("lu.hold");
        rf.wr_en = 1; rf.wr_addr = 8; rf.wr_data = 7; #1;
        chk("loaduse.wb_stall", 64'(rf.stall), 64'(!BYP));
        chk("loaduse.wb_data", 64'(rf.rs_data), BYP ? 64'(7) : 64'(0));
        cycle("lu.wb");
        rf.wr_en = 0; #1;
        chk("loaduse.after_stall", 64'(rf.stall), 64'(0));
        chk("loaduse.after_data", 64'(rf.rs_data), 64'(7));
        cycle("lu.after");

        do_reset();
        idle(); rf.issue_en = 1; rf.issue_dst = 9; #1; cycle("ss.issue");
        rf.wr_en = 1; rf.wr_addr = 9; rf.wr_data = 32'hA5; #1; cycle("ss.same");
        idle(); #1;
        chk("setclr.same_cnt", 64'(rf.pending_cnt), BYP ? 64'(1) : 64'(0));
        if (!BYP) begin rf.issue_en = 1; rf.issue_dst = 9; #1; cycle("ss.reissue"); end
        idle(); rf.wr_en = 1; rf.wr_addr = 9; rf.wr_data = 32'h5A; rf.issue_en = 1; rf.issue_dst = 10; #1;
        chk("setclr.diff_stall", 64'(rf.stall), 64'(0));
        cycle("ss.diff");
        idle(); #1;
        chk("setclr.diff_cnt", 64'(rf.pending_cnt), 64'(1));
        rf.rs_addr = 10; rf.rs_used = 1; #1;
        chk("setclr.r10_pending", 64'(rf.stall), 64'(1));
        rf.rs_addr = 9; #1;
        chk("setclr.r9_clear", 64'(rf.stall), 64'(0));
        chk("setclr.r9_data", 64'(rf.rs_data), 64'(32'h5A));
        cycle("ss.probe");

        do_reset();
        for (int r = 1; r <= 3; r++) begin
            idle(); rf.issue_en = 1; rf.issue_dst = reg_addr_t'(r); #1; cycle("mid.issue");
        end
        reset = 1; idle(); rf.wr_en = 1; rf.wr_addr = 1; rf.wr_data = 32'h55;
        rf.issue_en = 1; rf.issue_dst = 4; rf.rs_addr = 2; rf.rs_used = 1; #1;
        chk("midreset.stall_in_reset", 64'(rf.stall), 64'(0));
        cycle("mid.reset");
        reset = 0; idle(); rf.rs_addr = 1; rf.rt_addr = 2; rf.rs_used = 1; rf.rt_used = 1; #1;
        chk("midreset.cnt", 64'(rf.pending_cnt), 64'(0));
        chk("midreset.rs_data", 64'(rf.rs_data), 64'(0));
        chk("midreset.stall", 64'(rf.stall), 64'(0));
        cycle("mid.after");

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            rf.rs_addr = reg_addr_t'($urandom_range(0, 7)); rf.rt_addr = reg_addr_t'($urandom_range(0, 7));
            rf.rs_used = 1'($urandom); rf.rt_used = 1'($urandom);
            rf.wr_en = 1'($urandom); rf.wr_addr = reg_addr_t'($urandom_range(0, 7)); rf.wr_data = $urandom;
            rf.issue_en = 1'($urandom); rf.issue_dst = reg_addr_t'($urandom_range(0, 7));
            #1;
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/register_file.md
# register_file

Architectural 32-entry MIPS register file with an integrated pending-write scoreboard. It is the read side of the pipeline's writeback path: decode reads operands here, writeback writes results here. Decode also records destinations of issued instructions, so the block raises `stall` on RAW/WAW hazards against writes still in flight. It sits between the IF/ID pipeline register (operand addresses) and the ID/EX pipeline register (operand data).

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: address width; `NREG = 2**ADDR_W` entries.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rs_addr`  in  ADDR_W  read port A address.
- `rt_addr`  in  ADDR_W  read port B address.
- `rs_used`  in  1  decode instruction consumes rs.
- `rt_used`  in  1  decode instruction consumes rt.
- `rs_data`  out  DATA_W  read port A data, combinational.
- `rt_data`  out  DATA_W  read port B data, combinational.
- `wr_en`  in  1  writeback write strobe.
- `wr_addr`  in  ADDR_W  writeback destination.
- `wr_data`  in  DATA_W  writeback value.
- `issue_en`  in  1  decode instruction issues and will write `issue_dst`.
- `issue_dst`  in  ADDR_W  destination of issuing instruction.
- `stall`  out  1  hazard; decode must hold, combinational.
- `pending_cnt`  out  ADDR_W+1  number of registers with a write in flight, registered.

## Operation
- Register 0 is hardwired to zero. Reads of address 0 return 0. Writes to address 0 are dropped. Issue to address 0 never sets a pending bit.
- Write: when `wr_en` is high and `wr_addr != 0`, the entry is updated and `pending[wr_addr]` is cleared at the edge.
- Scoreboard: one pending bit per register.
  - `stall = (rs_used & pend_eff[rs_addr]) | (rt_used & pend_eff[rt_addr]) | (issue_en & pend_eff[issue_dst])`.
  - The third term is the WAW check.
- Issue is accepted only when `stall == 0`. An accepted issue with `issue_dst != 0` sets `pending[issue_dst]` at the edge.
- Simultaneous write and accepted issue:
  - Different registers: both take effect.
  - Same register: the set wins, the bit stays 1, and the array is still written.
- `pending_cnt` adds +1 for each set of a non-pending bit and −1 for each clear of a pending bit. The same-register case above yields a net change of 0. The count never exceeds `NREG-1`.

## Timing
- Read latency 0: data and `stall` are combinational from addresses and state.
- A write is visible in the array the cycle after the `wr_en` edge.
- A pending bit is set in the cycle after an accepted issue and cleared in the cycle after the write edge.
- Reset: all entries are 0, all pending bits are 0, and `pending_cnt` is 0 from the first cycle after `reset` is sampled high. This holds regardless of simultaneous `wr_en`/`issue_en`, and `reset` overrides both. While `reset` is high, `stall` is 0.
- Reset mid-operation discards all in-flight pending state.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Same-cycle write-to-read bypass. If `wr_en` and `wr_addr == rs_addr != 0`, then `rs_data = wr_data`; likewise for `rt`.
  - `pend_eff[r] = pending[r] & ~(wr_en & wr_addr == r)`, so a hazard clears in the writeback cycle itself.
- `REGFILE_BYPASS_EN` undefined:
  - Reads always return array contents.
  - `pend_eff = pending`, so a stall persists through the writeback cycle and releases one cycle later.
- Scoreboard set/clear and `pending_cnt` behaviour are identical in both builds.

## Structure
- Package `regfile_pkg` holds `DATA_W`, `ADDR_W`, `NREG`, the constant `ZERO_REG = 0`, and the `reg_addr_t`/`reg_data_t` typedefs.
- Sub-module `scoreboard` holds the pending vector, the `pend_eff` computation, the stall logic and `pending_cnt`. Top `register_file` holds the storage array and read muxes.

## Test plan
- Reset then read all: `reset` high 1 cycle, then sweep `rs_addr`/`rt_addr` 0..31 → all data 0, `stall` 0, `pending_cnt` 0.
- Write/read and zero register:
  - Write 0xDEADBEEF to r5 → next cycle `rs_data` = 0xDEADBEEF.
  - Write 0x1234 to r0 → `rs_data` for r0 stays 0.
- Load-use stall: issue r8, next cycle `rs_addr`=8 with `rs_used` → `stall` 1.
  - Write r8 = 7 with bypass → `stall` 0 and `rs_data` 7 in the same cycle.
  - Without bypass → `stall` 0 and data 7 one cycle later.
- WAW and count: issue r3 → `pending_cnt` 1. Issue r3 again → `stall` 1 and count stays 1. Issue r4 → count 2.
- Simultaneous set/clear: r9 pending; same cycle write r9 and accepted issue r9 → r9 still pending, count unchanged. Write r9 and issue r10 → count unchanged, r10 pending, r9 clear.
- Reset mid-flight: r1, r2, r3 pending; assert `reset` together with `wr_en` r1 → next cycle count 0, all data 0, `stall` 0.
